fake_n64_controller_tx: RTL and testbench

//  Response transmitter of the fake N64 controller; sits directly downstream of the RX stage.
//  A toggle on tx_handoff starts the reply. The reply is selected by the latched cmd, serialised
//  MSB-first in N64 pulse-width encoding on an open-drain line, and followed by a controller stop bit.
//  cur_operation drives the RX sampler's mode input; it stays high for the whole reply.

---
 rtl/fake_n64_pkg.sv | 77 +++++++
 rtl/fake_n64_bit_encoder.sv | 94 +++++++++
 rtl/fake_n64_controller_tx.sv | 162 ++++++++++++++++
 tb/tb_fake_n64_controller_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fake_n64_pkg.sv
// Shared constants, reply tables and state encodings for the fake N64 controller TX path.
// Optional feature macro: MEMPAK_EN (adds READ/WRITE replies and reports a pak as present).
package fake_n64_pkg;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [5:0] LEN_NONE   = 6'd0;
  localparam logic [5:0] LEN_INFO   = 6'd3;
  localparam logic [5:0] LEN_STATUS = 6'd4;
  localparam logic [5:0] LEN_READ   = 6'd33;
  localparam logic [5:0] LEN_WRITE  = 6'd1;

`ifdef MEMPAK_EN
  localparam logic [7:0] STAT_BYTE = 8'h01;
`else
  localparam logic [7:0] STAT_BYTE = 8'h02;
`endif

  localparam int BIT_US            = 4;
  localparam int BIT0_LO_US        = 3;
  localparam int BIT1_LO_US        = 1;
  localparam int STOP_LO_US        = 2;
  localparam int DEF_TURNAROUND_US = 2;
  localparam int DEF_GUARD_US      = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TURN, ST_BIT_LO, ST_BIT_HI, ST_STOP, ST_GUARD
  } tx_state_e;

  typedef enum logic [1:0] {
    ENC_IDLE, ENC_LO, ENC_HI
  } enc_phase_e;

  // Zero length means the command is not answered at all.
  function automatic logic [5:0] reply_len(input logic [7:0] cmd);
    case (cmd)
      CMD_INFO, CMD_RESET: reply_len = LEN_INFO;
      CMD_STATUS:          reply_len = LEN_STATUS;
`ifdef MEMPAK_EN
      CMD_READ:            reply_len = LEN_READ;
      CMD_WRITE:           reply_len = LEN_WRITE;
`endif
      default:             reply_len = LEN_NONE;
    endcase
  endfunction

  function automatic logic [7:0] reply_byte(input logic [7:0]  cmd,
                                            input logic [5:0]  idx,
                                            input logic [31:0] btn,
                                            input logic [7:0]  crc);
    reply_byte = 8'h00;
    case (cmd)
      CMD_INFO, CMD_RESET: begin
        case (idx)
          6'd0:    reply_byte = 8'h05;
          6'd1:    reply_byte = 8'h00;
          default: reply_byte = STAT_BYTE;
        endcase
      end
      CMD_STATUS: begin
        case (idx[1:0])
          2'd0:    reply_byte = btn[31:24];
          2'd1:    reply_byte = btn[23:16];
          2'd2:    reply_byte = btn[15:8];
          default: reply_byte = btn[7:0];
        endcase
      end
      CMD_WRITE: reply_byte = crc;
      default:   reply_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/fake_n64_bit_encoder.sv
// Drives one N64 pulse-width bit (or the 2 us controller stop bit) onto data_oe per start strobe.
// lo_done marks the end of a data bit's low phase; done marks the last cycle of the whole symbol.
module fake_n64_bit_encoder
  import fake_n64_pkg::*;
#(
  parameter int CLKS_PER_US = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  input  logic stop,
  output logic data_oe,
  output logic lo_done,
  output logic done
);

  localparam int CNT_W = $clog2(CLKS_PER_US * 3);

  localparam logic [CNT_W-1:0] LO0_LAST  = CNT_W'(BIT0_LO_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] LO1_LAST  = CNT_W'(BIT1_LO_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] HI0_LAST  = CNT_W'((BIT_US - BIT0_LO_US) * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] HI1_LAST  = CNT_W'((BIT_US - BIT1_LO_US) * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LO_US * CLKS_PER_US - 1);

  enc_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] phase_last;
  logic             at_last;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    phase_last = '0;
    lo_done    = 1'b0;
    done       = 1'b0;

    if (phase_q == ENC_LO)      phase_last = stop_q ? STOP_LAST : (bit_q ? LO1_LAST : LO0_LAST);
    else if (phase_q == ENC_HI) phase_last = bit_q ? HI1_LAST : HI0_LAST;
    at_last = (cnt_q == phase_last);

    case (phase_q)
      ENC_LO: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (at_last) begin
          cnt_d   = '0;
          phase_d = stop_q ? ENC_IDLE : ENC_HI;
          lo_done = !stop_q;
          done    = stop_q;
        end
      end
      ENC_HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (at_last) begin
          cnt_d   = '0;
          phase_d = ENC_IDLE;
          done    = 1'b1;
        end
      end
      default: phase_d = ENC_IDLE;
    endcase

    // The parent may chain the next symbol in the same cycle done is raised.
    if (start) begin
      phase_d = ENC_LO;
      cnt_d   = '0;
      bit_d   = bit_val;
      stop_d  = stop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      phase_q <= ENC_IDLE;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
    end
  end

  assign data_oe = (phase_q == ENC_LO);

endmodule

// File: rtl/fake_n64_controller_tx.sv
// Reply transmitter of the fake N64 controller: detects a tx_handoff toggle, then serialises
// the reply for the latched command MSB-first followed by a stop bit. Feature macro: MEMPAK_EN.
module fake_n64_controller_tx
  import fake_n64_pkg::*;
#(
  parameter int CLKS_PER_US   = 16,
  parameter int TURNAROUND_US = DEF_TURNAROUND_US,
  parameter int GUARD_US      = DEF_GUARD_US
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_handoff,
  input  logic [7:0]  cmd,
  input  logic [7:0]  crc,
  input  logic [31:0] button_state,
  output logic        data_oe,
  output logic        cur_operation,
  output logic        busy
);

  localparam int TMR_MAX = (TURNAROUND_US > GUARD_US ? TURNAROUND_US : GUARD_US) * CLKS_PER_US;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TURN_LAST  = TMR_W'(TURNAROUND_US * CLKS_PER_US - 1);
  localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(GUARD_US * CLKS_PER_US - 1);

  tx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [8:0]       count_q, count_d;
  logic [5:0]       len_q, len_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [31:0]      btn_q, btn_d;
  logic [7:0]       crc_val;
  logic [7:0]       cur_byte;
  logic             handoff_edge;
  logic             enc_start, enc_bit, enc_stop, enc_lo_done, enc_done;

`ifdef MEMPAK_EN
  logic [7:0] crc_q, crc_d;
  assign crc_val = crc_q;
`else
  logic unused_crc;
  assign unused_crc = ^crc;
  assign crc_val    = 8'h00;
`endif

  assign handoff_edge = sync2_q ^ prev_q;

  always_comb begin
    state_d   = state_q;
    sync1_d   = tx_handoff;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;  // tracked in every state, so toggles seen while busy are consumed
    tmr_d     = tmr_q;
    count_d   = count_q;
    len_d     = len_q;
    cmd_d     = cmd_q;
    btn_d     = btn_q;
`ifdef MEMPAK_EN
    crc_d     = crc_q;
`endif
    enc_start = 1'b0;
    enc_stop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (handoff_edge && (reply_len(cmd) != LEN_NONE)) begin
          state_d = ST_TURN;
          cmd_d   = cmd;
          btn_d   = button_state;
`ifdef MEMPAK_EN
          crc_d   = crc;
`endif
          len_d   = reply_len(cmd);
          count_d = '0;
          tmr_d   = '0;
        end
      end
      ST_TURN: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TURN_LAST) begin
          state_d   = ST_BIT_LO;
          enc_start = 1'b1;
          tmr_d     = '0;
        end
      end
      ST_BIT_LO: if (enc_lo_done) state_d = ST_BIT_HI;
      ST_BIT_HI: begin
        if (enc_done) begin
          count_d   = count_q + 9'd1;
          enc_start = 1'b1;
          if (count_d == {len_q, 3'b000}) begin
            state_d  = ST_STOP;
            enc_stop = 1'b1;
          end else begin
            state_d = ST_BIT_LO;
          end
        end
      end
      ST_STOP: begin
        if (enc_done) begin
          state_d = ST_GUARD;
          tmr_d   = '0;
        end
      end
      ST_GUARD: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == GUARD_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cur_byte = reply_byte(cmd_q, count_d[8:3], btn_q, crc_val);
    enc_bit  = cur_byte[3'd7 - count_d[2:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the handoff chain loads the live level during reset so release never looks like a toggle.
      sync1_q <= tx_handoff;
      sync2_q <= tx_handoff;
      prev_q  <= tx_handoff;
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
      btn_q   <= '0;
`ifdef MEMPAK_EN
      crc_q   <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      count_q <= count_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      btn_q   <= btn_d;
`ifdef MEMPAK_EN
      crc_q   <= crc_d;
`endif
    end
  end

  fake_n64_bit_encoder #(.CLKS_PER_US(CLKS_PER_US)) u_enc (
    .clk     (clk),
    .reset   (reset),
    .start   (enc_start),
    .bit_val (enc_bit),
    .stop    (enc_stop),
    .data_oe (data_oe),
    .lo_done (enc_lo_done),
    .done    (enc_done)
  );

  assign cur_operation = (state_q != ST_IDLE);
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fake_n64_controller_tx.sv
// Directed bench for fake_n64_controller_tx: decodes the open-drain line by low-pulse width.
// Honours MEMPAK_EN the same way the design does.
module tb_fake_n64_controller_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_handoff;
  logic [7:0]  cmd;
  logic [7:0]  crc;
  logic [31:0] button_state;
  logic        data_oe;
  logic        cur_operation;
  logic        busy;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

`ifdef MEMPAK_EN
  localparam logic [7:0] EXP_STAT = 8'h01;
`else
  localparam logic [7:0] EXP_STAT = 8'h02;
`endif

  always #5 clk = ~clk;

  fake_n64_controller_tx dut (
    .clk           (clk),
    .reset         (reset),
    .tx_handoff    (tx_handoff),
    .cmd           (cmd),
    .crc           (crc),
    .button_state  (button_state),
    .data_oe       (data_oe),
    .cur_operation (cur_operation),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the line to be pulled low, then returns the low width in clk; -1 on timeout.
  task automatic measure_low(output int lo);
    int n = 0;
    while (data_oe !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      lo = -1;
    end else begin
      lo = 0;
      while (data_oe === 1'b1 && lo < 200) begin
        lo++;
        tick();
      end
    end
  endtask

  task automatic read_byte(output logic [7:0] b, output int lo0, output int lo1);
    int lo;
    b = 8'h00;
    lo0 = 0;
    lo1 = 0;
    for (int i = 0; i < 8; i++) begin
      measure_low(lo);
      if (i == 0) lo0 = lo;
      if (i == 1) lo1 = lo;
      b = {b[6:0], (lo == 16)};
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    int lo0, lo1;
    read_byte(b, lo0, lo1);
    check(tag, {24'h0, b}, {24'h0, exp});
  endtask

  task automatic start_reply(input string tag);
    int n = 0;
    tx_handoff = ~tx_handoff;
    tick();
    tick();
    check({tag, "_lat2"}, {31'h0, cur_operation}, 32'h0);
    tick();
    check({tag, "_lat3"}, {31'h0, cur_operation}, 32'h1);
    while (data_oe !== 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check({tag, "_turn"}, n, 32);
  endtask

  task automatic finish_reply(input string tag);
    int lo;
    int n = 0;
    measure_low(lo);
    check({tag, "_stop"}, lo, 32);
    while (cur_operation === 1'b1 && n < 200) begin
      if (data_oe !== 1'b0) n = 1000;
      n++;
      tick();
    end
    check({tag, "_guard"}, n, 16);
    check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic no_reply(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (cur_operation !== 1'b0 || data_oe !== 1'b0) seen = 1'b1;
    end
    check(tag, {31'h0, seen}, 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] acc;
    int lo0, lo1, n;

    reset        = 1'b0;
    tx_handoff   = 1'b1;
    cmd          = 8'h00;
    crc          = 8'h00;
    button_state = 32'h0;
    repeat (5) tick();
    check("rst_data_oe", {31'h0, data_oe}, 32'h0);
    check("rst_cur_op", {31'h0, cur_operation}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    no_reply("t1_no_spurious", 1600);

    // INFO reply
    cmd = 8'h00;
    start_reply("t2");
    expect_byte("t2_b0", 8'h05);
    expect_byte("t2_b1", 8'h00);
    expect_byte("t2_stat", EXP_STAT);
    finish_reply("t2");
    repeat (20) tick();

    // STATUS reply with pulse-width checks on the first two bits
    cmd          = 8'h01;
    button_state = 32'h8000_7F81;
    start_reply("t3");
    read_byte(b, lo0, lo1);
    check("t3_b0", {24'h0, b}, 32'h80);
    check("t3_bit1_lo", lo0, 16);
    check("t3_bit0_lo", lo1, 48);
    expect_byte("t3_b1", 8'h00);
    expect_byte("t3_b2", 8'h7F);
    expect_byte("t3_b3", 8'h81);
    finish_reply("t3");
    repeat (20) tick();

    // WRITE reply
    cmd = 8'h03;
    crc = 8'hA5;
`ifdef MEMPAK_EN
    start_reply("t4");
    expect_byte("t4_crc", 8'hA5);
    finish_reply("t4");
`else
    tx_handoff = ~tx_handoff;
    no_reply("t4_no_write", 400);
`endif
    repeat (20) tick();

    // Toggle during a reply is discarded and the latched command stays in force
    cmd = 8'h00;
    start_reply("t5");
    tx_handoff = ~tx_handoff;
    cmd        = 8'h01;
    expect_byte("t5_b0", 8'h05);
    expect_byte("t5_b1", 8'h00);
    expect_byte("t5_stat", EXP_STAT);
    finish_reply("t5");
    no_reply("t5_no_second", 600);

    // Reset in the middle of a long reply
`ifdef MEMPAK_EN
    cmd = 8'h02;
    start_reply("t6");
    acc = 8'h00;
    for (int i = 0; i < 10; i++) begin
      read_byte(b, lo0, lo1);
      acc = acc | b;
    end
    check("t6_read_zero", {24'h0, acc}, 32'h0);
`else
    cmd          = 8'h01;
    button_state = 32'h8000_7F81;
    start_reply("t6");
    expect_byte("t6_b0", 8'h80);
    expect_byte("t6_b1", 8'h00);
`endif
    n = 0;
    while (data_oe !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("t6_line_low", {31'h0, data_oe}, 32'h1);
    reset = 1'b0;
    #1;
    check("t6_async_oe", {31'h0, data_oe}, 32'h0);
    check("t6_async_cur_op", {31'h0, cur_operation}, 32'h0);
    repeat (5) tick();
    reset = 1'b1;
    no_reply("t6_no_resume", 600);
    cmd = 8'h00;
    start_reply("t6_after");
    expect_byte("t6_after_b0", 8'h05);
    expect_byte("t6_after_b1", 8'h00);
    expect_byte("t6_after_stat", EXP_STAT);
    finish_reply("t6_after");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
